// File: rtl/alu_regfile_param.sv
// Parametrised register file with a shared ALU and {N,V,Z,C} flags on the CPU main bus.
// Define ALU_SHIFTN_EN to build the multi-cycle shift-by-N unit; otherwise op 7 is a combinational shr1.
module alu_regfile_param #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  inout  wire  [WIDTH-1:0]             main_bus,
  input  logic                         out_en,
  input  logic [$clog2(NREGS+2)-1:0]   out_sel,
  input  logic                         load_en,
  input  logic [$clog2(NREGS+2)-1:0]   load_sel,
  input  logic [$clog2(NREGS)-1:0]     arg_l,
  input  logic [$clog2(NREGS+1)-1:0]   arg_r,
  input  logic [2:0]                   op,
  input  logic                         cin,
  input  logic                         calc,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [3:0]                   fout
);

  localparam int SW = $clog2(NREGS+2);
  localparam int LW = $clog2(NREGS);
  localparam logic [SW-1:0] SEL_ALU   = SW'(NREGS);
  localparam logic [SW-1:0] SEL_FLAGS = SW'(NREGS+1);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] w_lVal, w_rVal, w_res, w_drvVal;
  logic [WIDTH:0]   w_addSum, w_subSum;
  logic             w_c, w_v, w_arith, w_drvEn;
  logic             w_shBusy, w_shWrite, w_shFlagUpd;
  logic [LW-1:0]    w_shDst;
  logic [WIDTH-1:0] w_shRes;
  logic [3:0]       w_shFlags;

  // Out-of-range operand indices (and arg_r == NREGS) read as zero.
  assign w_lVal   = (int'(arg_l) < NREGS) ? r_regs[arg_l] : '0;
  assign w_rVal   = (int'(arg_r) < NREGS) ? r_regs[arg_r[LW-1:0]] : '0;
  assign w_addSum = {1'b0, w_lVal} + {1'b0, w_rVal} + {{WIDTH{1'b0}}, cin};
  assign w_subSum = {1'b0, w_lVal} + {1'b0, ~w_rVal} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_arith = 1'b0;
    case (op)
      3'd0: begin
        w_res   = w_addSum[WIDTH-1:0];
        w_c     = w_addSum[WIDTH];
        w_v     = (w_lVal[WIDTH-1] == w_rVal[WIDTH-1]) && (w_addSum[WIDTH-1] != w_lVal[WIDTH-1]);
        w_arith = 1'b1;
      end
      3'd1: begin
        w_res   = w_subSum[WIDTH-1:0];
        w_c     = w_subSum[WIDTH];
        w_v     = (w_lVal[WIDTH-1] != w_rVal[WIDTH-1]) && (w_subSum[WIDTH-1] != w_lVal[WIDTH-1]);
        w_arith = 1'b1;
      end
      3'd2: w_res = w_lVal & w_rVal;
      3'd3: w_res = w_lVal | w_rVal;
      3'd4: w_res = w_lVal ^ w_rVal;
      3'd5: w_res = ~w_lVal;
      3'd6: begin
        w_res   = {w_lVal[WIDTH-2:0], cin};
        w_c     = w_lVal[WIDTH-1];
        w_arith = 1'b1;
      end
      default: begin
`ifdef ALU_SHIFTN_EN
        w_res = w_lVal;
`else
        w_res = {cin, w_lVal[WIDTH-1:1]};
        w_c   = w_lVal[0];
`endif
      end
    endcase
  end

  always_comb begin
    w_drvEn  = out_en;
    w_drvVal = '0;
    if (int'(out_sel) < NREGS)   w_drvVal = r_regs[out_sel[LW-1:0]];
    else if (out_sel == SEL_ALU)   w_drvVal = w_res;
    else if (out_sel == SEL_FLAGS) w_drvVal = WIDTH'(r_flags);
    else                           w_drvEn  = 1'b0;
  end

  assign main_bus = w_drvEn ? w_drvVal : 'z;
  assign fout     = r_flags;

`ifdef ALU_SHIFTN_EN
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} shState_t;

  shState_t         r_state, w_stateNext;
  logic [WIDTH-1:0] r_shVal, w_shStep;
  logic [CW-1:0]    r_shCnt, w_kInit;
  logic [LW-1:0]    r_shDst;
  logic             w_launch, w_kCap;

  assign w_launch = (r_state == IDLE) && start && (op == 3'd7);
  assign w_kCap   = ({1'b0, w_rVal} >= (WIDTH+1)'(WIDTH));
  assign w_kInit  = w_kCap ? CW'(WIDTH) : w_rVal[CW-1:0];
  assign w_shStep = {r_shVal[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_launch) w_stateNext = (w_kInit == '0) ? DONE : RUN;
      RUN:     if (r_shCnt == CW'(1)) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shVal <= '0;
      r_shCnt <= '0;
      r_shDst <= '0;
    end else if (w_launch) begin
      r_shVal <= w_lVal;
      r_shCnt <= w_kInit;
      r_shDst <= arg_l;
    end else if (r_state == RUN) begin
      r_shVal <= w_shStep;
      r_shCnt <= r_shCnt - CW'(1);
    end
  end

  // A zero-length shift only refreshes Z/N and clears C; V is left alone.
  assign w_shBusy    = (r_state == RUN);
  assign w_shWrite   = w_shBusy && (r_shCnt == CW'(1));
  assign w_shDst     = r_shDst;
  assign w_shRes     = w_shStep;
  assign w_shFlagUpd = w_shWrite || (w_launch && (w_kInit == '0));
  assign w_shFlags   = w_shWrite ? {w_shStep[WIDTH-1], 1'b0, (w_shStep == '0), r_shVal[WIDTH-1]}
                                 : {w_lVal[WIDTH-1], r_flags[2], (w_lVal == '0), 1'b0};
  assign busy        = w_shBusy;
  assign done        = (r_state == DONE);
`else
  logic w_unused;

  assign w_unused    = start;
  assign w_shBusy    = 1'b0;
  assign w_shWrite   = 1'b0;
  assign w_shDst     = '0;
  assign w_shRes     = '0;
  assign w_shFlagUpd = 1'b0;
  assign w_shFlags   = '0;
  assign busy        = 1'b0;
  assign done        = 1'b0;
`endif

  // Shift write-back beats a bus load; the destination is locked while the shifter runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_shWrite && (int'(w_shDst) == i))
          r_regs[i] <= w_shRes;
        else if (load_en && (int'(load_sel) == i) && !(w_shBusy && (int'(w_shDst) == i)))
          r_regs[i] <= main_bus;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flags <= '0;
    end else if (w_shFlagUpd) begin
      r_flags <= w_shFlags;
    end else if (load_en && (load_sel == SEL_FLAGS)) begin
      r_flags <= main_bus[3:0];
    end else if (calc && !w_shBusy) begin
      r_flags[3] <= w_res[WIDTH-1];
      r_flags[1] <= (w_res == '0);
      if (w_arith) begin
        r_flags[2] <= w_v;
        r_flags[0] <= w_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_regfile_param.sv
// Directed bench for alu_regfile_param (WIDTH=8, NREGS=4); covers both ALU_SHIFTN_EN builds.
module tb_alu_regfile_param;
  localparam int WIDTH = 8;
  localparam int NREGS = 4;

  logic             clk, rst;
  wire  [WIDTH-1:0] main_bus;
  logic             out_en, load_en, cin, calc, start;
  logic [2:0]       out_sel, load_sel, arg_r, op;
  logic [1:0]       arg_l;
  logic             busy, done;
  logic [3:0]       fout;
  logic             busEn;
  logic [WIDTH-1:0] busVal, rd;
  int               total, bad;
  int               busyCnt, latency, donePulses;

  assign main_bus = busEn ? busVal : 'z;

  alu_regfile_param #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .main_bus(main_bus), .out_en(out_en), .out_sel(out_sel),
    .load_en(load_en), .load_sel(load_sel), .arg_l(arg_l), .arg_r(arg_r), .op(op),
    .cin(cin), .calc(calc), .start(start), .busy(busy), .done(done), .fout(fout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] l, input logic [2:0] r, input logic [2:0] o, input logic c);
    arg_l = l; arg_r = r; op = o; cin = c;
  endtask

  task automatic loadReg(input logic [2:0] sel, input logic [WIDTH-1:0] v);
    busVal = v; busEn = 1'b1; load_en = 1'b1; load_sel = sel;
    tick();
    load_en = 1'b0; busEn = 1'b0;
  endtask

  task automatic readSel(input logic [2:0] sel, output logic [WIDTH-1:0] v);
    out_en = 1'b1; out_sel = sel;
    @(negedge clk);
    v = main_bus;
    out_en = 1'b0;
  endtask

  task automatic calcPulse();
    calc = 1'b1;
    tick();
    calc = 1'b0;
  endtask

  // Pulses start for one edge, then watches busy/done for maxEdges further edges.
  task automatic runShift(input int maxEdges);
    busyCnt = 0; latency = 0; donePulses = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= maxEdges; e++) begin
      if (busy) busyCnt++;
      if (done) begin
        donePulses++;
        if (latency == 0) latency = e;
      end
      tick();
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; busEn = 1'b0; busVal = '0;
    out_en = 0; out_sel = 0; load_en = 0; load_sel = 0;
    arg_l = 0; arg_r = 0; op = 0; cin = 0; calc = 0; start = 0;
    #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstFlags", fout, 4'h0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDone", done, 1'b0);
    rst = 1'b1;
    tick();

    loadReg(3'd1, 8'h5A);
    readSel(3'd1, rd);
    checkOutput("r1Load", rd, 8'h5A);
    #1 rst = 1'b0;
    #1;
    checkOutput("asyncRstFlags", fout, 4'h0);
    rst = 1'b1;
    readSel(3'd1, rd);
    checkOutput("r1AfterRst", rd, 8'h00);
    busEn = 1'b1; busVal = 8'h00;
    #1;
    checkOutput("busReleased", main_bus, 8'h00);
    busEn = 1'b0;

    loadReg(3'd0, 8'h7F);
    loadReg(3'd1, 8'h01);
    applyStimulus(2'd0, 3'd1, 3'd0, 1'b0);
    readSel(3'd4, rd);
    checkOutput("addRes", rd, 8'h80);
    calcPulse();
    checkOutput("addFlags", fout, 4'b1100);
    readSel(3'd5, rd);
    checkOutput("flagsOnBus", rd, 8'h0C);

    loadReg(3'd2, 8'h10);
    applyStimulus(2'd2, 3'd4, 3'd1, 1'b1);
    readSel(3'd4, rd);
    checkOutput("subZeroRes", rd, 8'h10);
    calcPulse();
    checkOutput("subZeroFlags", fout, 4'b0001);
    loadReg(3'd2, 8'h00);
    calcPulse();
    checkOutput("subZFlag", fout, 4'b0011);

    loadReg(3'd0, 8'hC3);
    loadReg(3'd1, 8'h5A);
    applyStimulus(2'd0, 3'd1, 3'd2, 1'b0);
    readSel(3'd4, rd);
    checkOutput("andRes", rd, 8'h42);
    calcPulse();
    checkOutput("andKeepsC", fout, 4'b0001);
    op = 3'd3; readSel(3'd4, rd); checkOutput("orRes", rd, 8'hDB);
    op = 3'd4; readSel(3'd4, rd); checkOutput("xorRes", rd, 8'h99);
    calcPulse();
    checkOutput("xorFlags", fout, 4'b1001);
    op = 3'd5; readSel(3'd4, rd); checkOutput("notRes", rd, 8'h3C);
    applyStimulus(2'd1, 3'd1, 3'd6, 1'b0);
    readSel(3'd4, rd);
    checkOutput("shl1Res", rd, 8'hB4);
    calcPulse();
    checkOutput("shl1Flags", fout, 4'b1000);

    applyStimulus(2'd0, 3'd1, 3'd0, 1'b0);
    busVal = 8'h05; busEn = 1'b1; load_en = 1'b1; load_sel = 3'd5; calc = 1'b1;
    tick();
    load_en = 1'b0; busEn = 1'b0; calc = 1'b0;
    checkOutput("flagsLoadWins", fout, 4'h5);

    loadReg(3'd2, 8'h77);
    loadReg(3'd3, 8'h99);
    busVal = 8'h00; busEn = 1'b1; out_en = 1'b1;
    for (int s = 6; s <= 7; s++) begin
      out_sel = 3'(s);
      #1;
      checkOutput($sformatf("invSel%0d", s), main_bus, 8'h00);
    end
    out_en = 1'b0; busEn = 1'b0;
    tick();

`ifdef ALU_SHIFTN_EN
    loadReg(3'd0, 8'h81);
    loadReg(3'd1, 8'd3);
    applyStimulus(2'd0, 3'd1, 3'd7, 1'b0);
    runShift(7);
    checkOutput("sh3Busy", busyCnt, 3);
    checkOutput("sh3Latency", latency, 4);
    checkOutput("sh3DonePulses", donePulses, 1);
    readSel(3'd0, rd);
    checkOutput("sh3Res", rd, 8'h08);
    checkOutput("sh3Flags", fout, 4'b0000);

    loadReg(3'd0, 8'h81);
    loadReg(3'd1, 8'd20);
    runShift(12);
    checkOutput("sh20Busy", busyCnt, 8);
    checkOutput("sh20Latency", latency, 9);
    readSel(3'd0, rd);
    checkOutput("sh20Res", rd, 8'h00);
    checkOutput("sh20Flags", fout, 4'b0011);

    loadReg(3'd0, 8'h81);
    loadReg(3'd1, 8'd0);
    loadReg(3'd5, 8'h0F);
    runShift(4);
    checkOutput("sh0Busy", busyCnt, 0);
    checkOutput("sh0Latency", latency, 1);
    checkOutput("sh0Flags", fout, 4'b1100);
    readSel(3'd0, rd);
    checkOutput("sh0Res", rd, 8'h81);

    loadReg(3'd1, 8'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    loadReg(3'd0, 8'hFF);
    loadReg(3'd3, 8'h33);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("collDone", done, 1'b1);
    busyCnt = 0; donePulses = 0;
    for (int e = 0; e < 5; e++) begin
      tick();
      if (busy) busyCnt++;
      if (done) donePulses++;
    end
    checkOutput("collNoRestart", busyCnt + donePulses, 0);
    readSel(3'd0, rd);
    checkOutput("collR0", rd, 8'h08);
    readSel(3'd3, rd);
    checkOutput("collR3", rd, 8'h33);

    loadReg(3'd0, 8'h81);
    loadReg(3'd5, 8'h0F);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("midBusy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    checkOutput("midRstBusy", busy, 1'b0);
    checkOutput("midRstDone", done, 1'b0);
    checkOutput("midRstFlags", fout, 4'h0);
    rst = 1'b1;
    readSel(3'd0, rd);
    checkOutput("midRstR0", rd, 8'h00);
    readSel(3'd1, rd);
    checkOutput("midRstR1", rd, 8'h00);
    tick();
    loadReg(3'd0, 8'h01);
    loadReg(3'd1, 8'd2);
    runShift(6);
    checkOutput("freshLatency", latency, 3);
    checkOutput("freshBusy", busyCnt, 2);
    readSel(3'd0, rd);
    checkOutput("freshRes", rd, 8'h04);
`else
    loadReg(3'd0, 8'h81);
    loadReg(3'd5, 8'h00);
    applyStimulus(2'd0, 3'd4, 3'd7, 1'b1);
    readSel(3'd4, rd);
    checkOutput("shr1Cin1", rd, 8'hC0);
    calcPulse();
    checkOutput("shr1NZ", {fout[3], fout[1]}, 2'b10);
    cin = 1'b0;
    readSel(3'd4, rd);
    checkOutput("shr1Cin0", rd, 8'h40);
    busyCnt = 0; donePulses = 0;
    start = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      if (busy) busyCnt++;
      if (done) donePulses++;
    end
    start = 1'b0;
    checkOutput("startIgnored", busyCnt + donePulses, 0);
    readSel(3'd0, rd);
    checkOutput("r0Unchanged", rd, 8'h81);
    loadReg(3'd0, 8'h01);
    calcPulse();
    checkOutput("shr1ZFlag", {fout[3], fout[1]}, 2'b01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
